// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator front-end.
//   state_t     - sequencer states
//   evt_t       - conditioned button events, declared in arbitration order
//                 (earlier value wins when several fire in one cycle)
//   BTN_*       - bit positions of the buttons in the raw/press vectors
//   pick_event  - same-cycle arbitration: clear > enter > total > digit
package calc_pkg;

  localparam int DIGIT_W_DEF = 4;

  localparam int NUM_BTN   = 4;
  localparam int BTN_DIGIT = 0;
  localparam int BTN_TOTAL = 1;
  localparam int BTN_ENTER = 2;
  localparam int BTN_CLEAR = 3;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    HELD,
    BUSY
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLEAR,
    EV_ENTER,
    EV_TOTAL,
    EV_DIGIT
  } evt_t;

  // Lower-priority events in the same cycle are simply lost.
  function automatic evt_t pick_event(input logic clr, input logic ent,
                                      input logic tot, input logic dig);
    if (clr) return EV_CLEAR;
    if (ent) return EV_ENTER;
    if (tot) return EV_TOTAL;
    if (dig) return EV_DIGIT;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: one push-button front end.
//   raw   - asynchronous button level
//   press - 1-cycle registered pulse on each accepted (debounced) rising edge
// A 2-flop synchronizer feeds a debounce counter; the filtered level follows
// the synchronized level only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement. Any agreeing cycle restarts the count.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2, filt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != filt) begin
        if (cnt == CNT_LAST) begin
          // Flip now; press is raised in the same edge so the event lines
          // up with the new filtered level. Releases give no pulse.
          filt  <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: button front end and entry/store/add sequencer.
//   clk, reset_n             - clock, async active-low reset
//   btn_digit/enter/total/clear - raw asynchronous buttons
//   digit_val                - digit code captured on the digit event
//   dp_ready                 - datapath finished a store/add
//   cmd_shift/store/add/clear - 1-cycle registered command strobes
//   digit_out                - digit code accompanying cmd_shift
//   show                     - display accumulator (1) or entry (0)
//   entry_len                - digits in the entry register (saturating)
//   acc_valid                - accumulator holds an operand
//   busy                     - waiting on dp_ready
//   err                      - sticky entry overflow
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4,
  parameter int DIGIT_W         = DIGIT_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              btn_digit,
  input  logic [DIGIT_W-1:0]                digit_val,
  input  logic                              btn_enter,
  input  logic                              btn_total,
  input  logic                              btn_clear,
  input  logic                              dp_ready,
  output logic                              cmd_shift,
  output logic [DIGIT_W-1:0]                digit_out,
  output logic                              cmd_store,
  output logic                              cmd_add,
  output logic                              cmd_clear,
  output logic                              show,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_len,
  output logic                              acc_valid,
  output logic                              busy,
  output logic                              err
);

  localparam int LEN_W = $clog2(NUM_DIGITS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_DIGITS);

  logic [NUM_BTN-1:0] raw, press;
  evt_t               ev;
  state_t             state;
  logic               armed;  // dp_ready is ignored during the strobe cycle

  always_comb begin
    raw            = '0;
    raw[BTN_DIGIT] = btn_digit;
    raw[BTN_TOTAL] = btn_total;
    raw[BTN_ENTER] = btn_enter;
    raw[BTN_CLEAR] = btn_clear;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw[i]),
      .press   (press[i])
    );
  end

  assign ev = pick_event(press[BTN_CLEAR], press[BTN_ENTER],
                         press[BTN_TOTAL], press[BTN_DIGIT]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      armed     <= 1'b0;
      cmd_shift <= 1'b0;
      cmd_store <= 1'b0;
      cmd_add   <= 1'b0;
      cmd_clear <= 1'b0;
      digit_out <= '0;
      show      <= 1'b0;
      entry_len <= '0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_shift <= 1'b0;
      cmd_store <= 1'b0;
      cmd_add   <= 1'b0;
      cmd_clear <= 1'b0;

      // Captured on every digit press; only meaningful alongside cmd_shift.
      if (press[BTN_DIGIT]) digit_out <= digit_val;

      if (ev == EV_CLEAR) begin
        // Clear overrides everything, including an outstanding dp_ready wait.
        cmd_clear <= 1'b1;
        state     <= EMPTY;
        armed     <= 1'b0;
        show      <= 1'b0;
        entry_len <= '0;
        acc_valid <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b0;
      end else if (state == BUSY) begin
        if (!armed) begin
          armed <= 1'b1;
        end else if (dp_ready) begin
          acc_valid <= 1'b1;
          entry_len <= '0;
          err       <= 1'b0;
          busy      <= 1'b0;
          state     <= HELD;
        end
      end else begin
        unique case (ev)
          EV_ENTER: begin
            // Only a freshly typed entry is added; HELD/EMPTY re-store.
            if (state == ENTRY && acc_valid) cmd_add   <= 1'b1;
            else                             cmd_store <= 1'b1;
            state <= BUSY;
            busy  <= 1'b1;
            armed <= 1'b0;
          end
          EV_TOTAL: show <= ~show;
          EV_DIGIT: begin
            // entry_len is 0 in EMPTY/HELD, so only ENTRY can overflow.
            if (entry_len < LEN_MAX) begin
              cmd_shift <= 1'b1;
              entry_len <= entry_len + 1'b1;
              state     <= ENTRY;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: reset checks, a table of single-press
// scenarios, hand-written multi-cycle corner cases, then random presses
// compared every cycle against a behavioural model.
module tb_calc_input_sequencer;

  localparam int D = 4;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_digit, btn_enter, btn_total, btn_clear, dp_ready;
  logic [3:0] digit_val;
  logic       cmd_shift, cmd_store, cmd_add, cmd_clear;
  logic [3:0] digit_out;
  logic       show, acc_valid, busy, err;
  logic [2:0] entry_len;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(D), .NUM_DIGITS(N), .DIGIT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_digit(btn_digit), .digit_val(digit_val),
    .btn_enter(btn_enter), .btn_total(btn_total), .btn_clear(btn_clear),
    .dp_ready(dp_ready), .cmd_shift(cmd_shift), .digit_out(digit_out),
    .cmd_store(cmd_store), .cmd_add(cmd_add), .cmd_clear(cmd_clear),
    .show(show), .entry_len(entry_len), .acc_valid(acc_valid), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button index: 0 digit, 1 total, 2 enter, 3 clear.
  logic [15:0] hist [4];   // hist[b][j] = raw sample j+1 edges ago
  logic        mfilt [4];
  logic [3:0]  pend;       // press events seen by the sequencer next edge
  logic        m_shift, m_store, m_add, m_clear, m_show, m_acc, m_busy, m_err;
  int          m_len, m_age;
  logic [3:0]  m_dig;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 4; b++) begin hist[b] = '0; mfilt[b] = 1'b0; end
      pend = '0;
      {m_shift, m_store, m_add, m_clear, m_show, m_acc, m_busy, m_err} = '0;
      m_len = 0; m_age = 0; m_dig = '0;
    end else begin
      logic [3:0] rawv, nev;
      logic       alldiff;
      {m_shift, m_store, m_add, m_clear} = '0;
      if (pend[3]) begin
        m_clear = 1; m_show = 0; m_len = 0; m_acc = 0; m_err = 0; m_busy = 0;
      end else if (m_busy) begin
        if (m_age >= 1 && dp_ready) begin
          m_acc = 1; m_len = 0; m_err = 0; m_busy = 0;
        end
        m_age++;
      end else if (pend[2]) begin
        if (m_acc && m_len > 0) m_add = 1; else m_store = 1;
        m_busy = 1; m_age = 0;
      end else if (pend[1]) begin
        m_show = !m_show;
      end else if (pend[0]) begin
        if (m_len < N) begin m_shift = 1; m_len++; end else m_err = 1;
      end
      if (pend[0]) m_dig = digit_val;
      // Filtered level flips once the synchronized samples (2 edges late)
      // have disagreed with it for D edges in a row.
      rawv = {btn_clear, btn_enter, btn_total, btn_digit};
      for (int b = 0; b < 4; b++) begin
        nev[b]  = 1'b0;
        alldiff = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[b][j] == mfilt[b]) alldiff = 1'b0;
        if (alldiff) begin mfilt[b] = !mfilt[b]; nev[b] = mfilt[b]; end
        hist[b] = {hist[b][14:0], rawv[b]};
      end
      pend = nev;
    end
  end

  // ---------------- cycle helper ----------------
  int n_shift, n_store, n_add, n_clear, n_busy;
  int last_dig;
  int dp_mode;   // 0 respond after dp_delay, 1 random, 2 held low
  int dp_delay = 1;
  int cd = 0;

  task automatic tick();
    logic [10:0] act, exp;
    @(negedge clk);
    act = {cmd_shift, cmd_store, cmd_add, cmd_clear, show, entry_len, acc_valid, busy, err};
    exp = {m_shift, m_store, m_add, m_clear, m_show, 3'(m_len), m_acc, m_busy, m_err};
    chk("model_outputs", int'(act), int'(exp));
    if (cmd_shift && m_shift) chk("model_digit_out", int'(digit_out), int'(m_dig));
    n_shift += int'(cmd_shift); n_store += int'(cmd_store);
    n_add   += int'(cmd_add);   n_clear += int'(cmd_clear);
    n_busy  += int'(busy);
    if (cmd_shift) last_dig = int'(digit_out);
    case (dp_mode)
      0: begin
        dp_ready = 1'b0;
        if (cd > 0) begin cd--; if (cd == 0) dp_ready = 1'b1; end
        if (cmd_store || cmd_add) cd = dp_delay;
      end
      1: dp_ready = ($urandom_range(0, 3) == 0);
      default: dp_ready = 1'b0;
    endcase
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_digit = v;
      1: btn_total = v;
      2: btn_enter = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input logic [3:0] v, input int gap);
    digit_val = v;
    set_btn(b, 1'b1);
    repeat (hold) tick();
    set_btn(b, 1'b0);
    repeat (gap) tick();
  endtask

  typedef struct {
    int b; int hold; logic [3:0] val;
    int e_shift; int e_store; int e_add; int e_clear;
    int e_show; int e_len; int e_acc; int e_err; int e_dig;
  } vec_t;

  vec_t vt [15];

  initial begin
    int s0, st0, a0, c0;
    // b hold val | shift store add clear | show len acc err | dig
    vt[0]  = '{2, 3, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    vt[1]  = '{0, 6, 4'd1, 1, 0, 0, 0, 0, 1, 0, 0,  1};
    vt[2]  = '{0, 4, 4'd2, 1, 0, 0, 0, 0, 2, 0, 0,  2};
    vt[3]  = '{2, 5, 4'd0, 0, 1, 0, 0, 0, 0, 1, 0, -1};
    vt[4]  = '{1, 5, 4'd0, 0, 0, 0, 0, 1, 0, 1, 0, -1};
    vt[5]  = '{0, 5, 4'd3, 1, 0, 0, 0, 1, 1, 1, 0,  3};
    vt[6]  = '{2, 5, 4'd0, 0, 0, 1, 0, 1, 0, 1, 0, -1};
    vt[7]  = '{1, 5, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, -1};
    vt[8]  = '{0, 5, 4'd9, 1, 0, 0, 0, 0, 1, 1, 0,  9};
    vt[9]  = '{0, 5, 4'd8, 1, 0, 0, 0, 0, 2, 1, 0,  8};
    vt[10] = '{0, 5, 4'd7, 1, 0, 0, 0, 0, 3, 1, 0,  7};
    vt[11] = '{0, 5, 4'd6, 1, 0, 0, 0, 0, 4, 1, 0,  6};
    vt[12] = '{0, 5, 4'd5, 0, 0, 0, 0, 0, 4, 1, 1, -1};
    vt[13] = '{2, 5, 4'd0, 0, 0, 1, 0, 0, 0, 1, 0, -1};
    vt[14] = '{3, 5, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0, -1};

    {btn_digit, btn_enter, btn_total, btn_clear, dp_ready} = '0;
    digit_val = '0;
    n_shift = 0; n_store = 0; n_add = 0; n_clear = 0; n_busy = 0; last_dig = -1;
    dp_mode = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        int'({cmd_shift, cmd_store, cmd_add, cmd_clear, show, entry_len, acc_valid, busy, err, digit_out}), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // ---- table of single presses ----
    for (int i = 0; i < 15; i++) begin
      s0 = n_shift; st0 = n_store; a0 = n_add; c0 = n_clear;
      press(vt[i].b, vt[i].hold, vt[i].val, 14);
      chk($sformatf("v%0d_shift", i), n_shift - s0, vt[i].e_shift);
      chk($sformatf("v%0d_store", i), n_store - st0, vt[i].e_store);
      chk($sformatf("v%0d_add", i), n_add - a0, vt[i].e_add);
      chk($sformatf("v%0d_clear", i), n_clear - c0, vt[i].e_clear);
      chk($sformatf("v%0d_show", i), int'(show), vt[i].e_show);
      chk($sformatf("v%0d_len", i), int'(entry_len), vt[i].e_len);
      chk($sformatf("v%0d_acc", i), int'(acc_valid), vt[i].e_acc);
      chk($sformatf("v%0d_err", i), int'(err), vt[i].e_err);
      if (vt[i].e_dig >= 0) chk($sformatf("v%0d_digit", i), last_dig, vt[i].e_dig);
    end

    // ---- exact press-to-strobe latency, then busy length ----
    n_busy = 0;
    btn_enter = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk($sformatf("lat_store_%0d", i), int'(cmd_store), (i == 6) ? 1 : 0);
    end
    btn_enter = 1'b0;
    repeat (14) tick();
    chk("lat_busy_cycles", n_busy, 2);
    chk("lat_acc_valid", int'(acc_valid), 1);

    // ---- clear and enter together: clear wins ----
    s0 = n_store; c0 = n_clear;
    btn_clear = 1'b1; btn_enter = 1'b1;
    repeat (6) tick();
    btn_clear = 1'b0; btn_enter = 1'b0;
    repeat (14) tick();
    chk("pri_clear_cnt", n_clear - c0, 1);
    chk("pri_store_cnt", n_store - s0, 0);
    chk("pri_acc_valid", int'(acc_valid), 0);
    chk("pri_busy", int'(busy), 0);

    // ---- total ignored while busy, clear abandons the wait ----
    press(1, 5, 4'd0, 14);
    chk("busy_show_on", int'(show), 1);
    dp_mode = 2;
    press(2, 5, 4'd0, 4);
    chk("busy_entered", int'(busy), 1);
    press(1, 5, 4'd0, 10);
    chk("busy_total_dropped", int'(show), 1);
    c0 = n_clear;
    press(3, 5, 4'd0, 10);
    chk("busy_clear_cnt", n_clear - c0, 1);
    chk("busy_cleared", int'(busy), 0);
    chk("busy_show_off", int'(show), 0);
    chk("busy_acc_valid", int'(acc_valid), 0);

    // ---- async reset in the middle of a busy wait ----
    press(2, 5, 4'd0, 4);
    chk("rst_busy_before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outputs",
           int'({cmd_shift, cmd_store, cmd_add, cmd_clear, show, entry_len, acc_valid, busy, err, digit_out}), 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // ---- random presses, glitches and collisions vs the model ----
    dp_mode = 1;
    for (int k = 0; k < 300; k++) begin
      int r, b, b2;
      r = $urandom_range(0, 99);
      b = (r < 40) ? 0 : (r < 62) ? 2 : (r < 80) ? 1 : 3;
      if (r >= 88 && r < 95) begin
        b2 = $urandom_range(0, 3);
        digit_val = 4'($urandom);
        set_btn(b, 1'b1); set_btn(b2, 1'b1);
        repeat ($urandom_range(3, 8)) tick();
        set_btn(b, 1'b0); set_btn(b2, 1'b0);
        repeat ($urandom_range(0, 9)) tick();
      end else if (r >= 95) begin
        press($urandom_range(0, 3), $urandom_range(1, 3), 4'($urandom), $urandom_range(0, 6));
      end else begin
        press(b, $urandom_range(3, 8), 4'($urandom), $urandom_range(0, 9));
      end
    end
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
Front-end controller for the calculator datapath. Conditions the four raw push-buttons (digit, enter, total, clear), arbitrates simultaneous presses, and runs the entry/store/add state machine. Issues one-cycle command strobes to the operand/accumulator datapath and waits for its completion handshake. Sits between the board button pins and the accumulator/display datapath.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles before a synchronized button level is accepted (≥1)
NUM_DIGITS, 4, maximum digits in the entry register
DIGIT_W, 4, width of one digit code

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
btn_digit  in  1  raw digit-key level (asynchronous)
digit_val  in  DIGIT_W  digit code, sampled with btn_digit's press event
btn_enter  in  1  raw enter key
btn_total  in  1  raw total key
btn_clear  in  1  raw clear key
dp_ready  in  1  datapath completion of store/add
cmd_shift  out  1  1-cycle pulse: shift digit_out into entry register
digit_out  out  DIGIT_W  digit code, valid with cmd_shift
cmd_store  out  1  1-cycle pulse: entry → accumulator (replace)
cmd_add  out  1  1-cycle pulse: accumulator += entry
cmd_clear  out  1  1-cycle pulse: clear datapath
show  out  1  level: display accumulator (1) or entry (0)
entry_len  out  $clog2(NUM_DIGITS+1)  digits currently entered
acc_valid  out  1  accumulator holds a stored operand
busy  out  1  waiting on dp_ready
err  out  1  sticky entry-overflow flag

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state EMPTY, debounce/sync state cleared; takes effect immediately, including mid-operation.
- Per button: 2-flop synchronizer, then debounce counter; filtered level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. A counter reset on any mismatch break. Press event = filtered rising edge (1 cycle). Release produces no event.
- Latency: raw high first sampled at edge t and held → filtered high after edge t+1+DEBOUNCE_CYCLES → command strobe high in the cycle after edge t+2+DEBOUNCE_CYCLES.
- Same-cycle events: priority clear > enter > total > digit. Lower events in that cycle are dropped, not queued.
- digit_val is registered into digit_out on the digit event.
- States:
  - EMPTY: digit → cmd_shift, go ENTRY. enter → cmd_store, go BUSY.
  - ENTRY: digit → cmd_shift if entry_len<NUM_DIGITS, else no strobe and err=1. enter → cmd_add if acc_valid, else cmd_store; go BUSY.
  - HELD: digit → cmd_shift, go ENTRY. enter → cmd_store (re-store), go BUSY.
  - BUSY: dp_ready is sampled from the first cycle after the strobe. When it is seen: acc_valid=1, entry_len=0, err=0, go HELD. Digit, enter and total events are dropped while in BUSY.
- total event, in any state except BUSY: show toggles.
- clear event, in any state including BUSY: cmd_clear pulse; go EMPTY; show, entry_len, acc_valid, err and busy all cleared; the pending dp_ready wait is abandoned.
- busy = (state==BUSY). entry_len increments on every cmd_shift and saturates at NUM_DIGITS.
- Only one cmd_* strobe is ever high in a cycle. Strobes are registered outputs.

Decomposition:
- Package calc_pkg: state enum {EMPTY, ENTRY, HELD, BUSY}, event-priority constants, DIGIT_W default.
- Sub-module btn_conditioner (sync + debounce + rising-edge detect, parameter DEBOUNCE_CYCLES), instantiated four times.

Test Plan:
- Press digit 1, then digit 2, then enter; dp_ready 2 cycles after cmd_store → cmd_shift ×2 with digit_out=1 then 2, entry_len=2; then cmd_store; busy=1 for 2 cycles; then acc_valid=1, entry_len=0, state HELD.
- From HELD: digit 3, enter → cmd_shift with digit_out=3, then cmd_add (not cmd_store); busy until dp_ready.
- DEBOUNCE_CYCLES=4: btn_enter high 3 cycles → no strobe. Held high from edge t → cmd_store high in the cycle after edge t+6.
- btn_clear and btn_enter rise together → only cmd_clear; state EMPTY, acc_valid=0.
- Five digit presses with NUM_DIGITS=4 → four cmd_shift pulses, entry_len=4, err=1; next enter clears err after dp_ready.
- Total pressed twice → show 0→1→0. Enter, then clear pressed while busy with dp_ready held low → cmd_clear, busy=0, show=0, state EMPTY. Assert reset_n mid-BUSY → all outputs 0 immediately.
